// File: rtl/sub_bytes_iter_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the folded SubBytes engine.
// The sbox is computed as GF inverse followed by the affine map, so no 256-entry tables are stored.
package sub_bytes_iter_pkg;

  localparam int   AES_STATE_W = 128;
  localparam int   AES_BYTES   = 16;
  localparam logic MODE_ENC    = 1'b0;
  localparam logic MODE_DEC    = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse for a != 0 and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

endpackage

// File: rtl/sub_bytes_iter_lane.sv
// One substitution lane: forward sbox and inverse sbox side by side, selected by the latched mode.
module sub_bytes_iter_lane
  import sub_bytes_iter_pkg::*;
(
  input  logic [7:0] s_in,
  input  logic       inv,
  output logic [7:0] s_out
);

  logic [7:0] fwd;
  logic [7:0] bwd;

  always_comb begin
    fwd = affine_fwd(gf_inv(s_in));
    bwd = gf_inv(affine_inv(s_in));
  end

  assign s_out = (inv == MODE_DEC) ? bwd : fwd;

endmodule

// File: rtl/sub_bytes_iter.sv
// Folded, handshaked AES SubBytes / InvSubBytes engine: NUM_SBOX lanes per beat, 16/NUM_SBOX beats per state.
module sub_bytes_iter
  import sub_bytes_iter_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data,
  output logic                   busy
);

  localparam int BEATS  = AES_BYTES / NUM_SBOX;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_W = 8 * NUM_SBOX;

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
    $error("sub_bytes_iter: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   inv_q;
  logic [AES_STATE_W-1:0] work;
  logic [AES_STATE_W-1:0] work_next;
  logic [BEAT_W-1:0]      beat_in;
  logic [BEAT_W-1:0]      beat_out;
  logic                   last_beat;

  // The beat counter picks which contiguous group of NUM_SBOX bytes goes through the lanes.
  always_comb begin
    beat_in   = work[32'(cnt) * BEAT_W +: BEAT_W];
    last_beat = (32'(cnt) == BEATS - 1);
    work_next = work;
    work_next[32'(cnt) * BEAT_W +: BEAT_W] = beat_out;
  end

  for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
    sub_bytes_iter_lane u_lane (
      .s_in  (beat_in[8*l +: 8]),
      .inv   (inv_q),
      .s_out (beat_out[8*l +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      inv_q     <= MODE_ENC;
      work      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            inv_q    <= in_inv;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          work <= work_next;
          if (last_beat) begin
            cnt       <= '0;
            out_data  <= work_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter against sbox tables derived from GF(2^8) arithmetic.
module tb_sub_bytes_iter;

  localparam int NUM_SBOX = 4;
  localparam int BEATS    = 16 / NUM_SBOX;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int fails  = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  sub_bytes_iter #(.NUM_SBOX(NUM_SBOX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Carry-less product reduced by long division modulo x^8+x^4+x^3+x+1.
  function automatic int ref_mul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int k = 14; k >= 8; k--) if (((p >> k) & 1) != 0) p = p ^ (32'h11b << (k - 8));
    return p & 8'hff;
  endfunction

  function automatic logic [7:0] ref_sbox(input int x);
    int inv_x;
    logic [7:0] r;
    inv_x = 0;
    for (int y = 1; y < 256; y++) if (ref_mul(x, y) == 1) inv_x = y;
    for (int i = 0; i < 8; i++)
      r[i] = 1'(((inv_x >> i) ^ (inv_x >> ((i + 4) % 8)) ^ (inv_x >> ((i + 5) % 8)) ^
                 (inv_x >> ((i + 6) % 8)) ^ (inv_x >> ((i + 7) % 8)) ^ (8'h63 >> i)) & 1);
    return r;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = inv ? inv_tab[d[8*j +: 8]] : fwd_tab[d[8*j +: 8]];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one state, then waits (bounded) for the result; returns cycles from accept to out_valid.
  task automatic applyStimulus(input logic [127:0] d, input logic inv, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = ~inv;
    checkOutput("busy_after_accept", busy, 1'b1);
    checkOutput("ready_low_busy", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("out_valid_seen", out_valid, 1'b1);
  endtask

  task automatic finishState(input logic [127:0] exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("post_hs_ready", in_ready, 1'b1);
    checkOutput("post_hs_valid", out_valid, 1'b0);
    checkOutput("post_hs_hold", out_data, exp);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int           lat;
    logic [127:0] d;
    logic [127:0] e;
    logic [127:0] pend;
    logic         m;

    for (int x = 0; x < 256; x++) fwd_tab[x] = ref_sbox(x);
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_out_data", out_data, 128'h0);
    checkOutput("reset_busy", busy, 1'b0);

    // All-zero state, forward: every byte becomes 63 after exactly BEATS cycles.
    applyStimulus(128'h0, 1'b0, lat);
    checkOutput("zero_enc", out_data, {16{8'h63}});
    checkOutput("zero_latency", 128'(lat), 128'(BEATS));
    finishState({16{8'h63}});

    // FIPS-197 SubBytes vector and its inverse.
    applyStimulus(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, lat);
    checkOutput("fips_enc", out_data, 128'hd42711aee0bf98f1b8b45de51e415230);
    finishState(128'hd42711aee0bf98f1b8b45de51e415230);
    applyStimulus(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, lat);
    checkOutput("fips_dec", out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    checkOutput("dec_latency", 128'(lat), 128'(BEATS));
    finishState(128'h193de3bea0f4e22b9ac68d2ae9f84808);

    // Single marked byte walked across every position, both directions.
    for (int p = 0; p < 16; p++) begin
      d = '0;
      d[8*p +: 8] = 8'h53;
      e = {16{8'h63}};
      e[8*p +: 8] = 8'hed;
      applyStimulus(d, 1'b0, lat);
      checkOutput($sformatf("pos_enc_%0d", p), out_data, e);
      finishState(e);
      d = {16{8'h63}};
      d[8*p +: 8] = 8'hed;
      e = '0;
      e[8*p +: 8] = 8'h53;
      applyStimulus(d, 1'b1, lat);
      checkOutput($sformatf("pos_dec_%0d", p), out_data, e);
      finishState(e);
    end

    // Backpressure: result held for 10 cycles while a second state is waiting.
    d    = {$urandom, $urandom, $urandom, $urandom};
    pend = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(d, 1'b0, lat);
    e = ref_state(d, 1'b0);
    in_valid = 1'b1;
    in_data  = pend;
    in_inv   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("bp_data_stable", out_data, e);
      checkOutput("bp_valid_held", out_valid, 1'b1);
      checkOutput("bp_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_release_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_pending_accepted", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("bp_pending_result", out_data, ref_state(pend, 1'b1));
    finishState(ref_state(pend, 1'b1));

    // Reset landing on beat 1 aborts the transaction with no output.
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_out_valid", out_valid, 1'b0);
    checkOutput("abort_out_data", out_data, 128'h0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_in_ready", in_ready, 1'b1);
    repeat (BEATS + 2) @(negedge clk);
    checkOutput("abort_no_output", out_valid, 1'b0);
    d = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(d, 1'b1, lat);
    checkOutput("after_abort", out_data, ref_state(d, 1'b1));
    finishState(ref_state(d, 1'b1));

    // Exhaustive byte sweep: sixteen states cover 0..255 in each mode.
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) d[8*j +: 8] = 8'(16 * k + j);
      for (int md = 0; md < 2; md++) begin
        m = 1'(md);
        applyStimulus(d, m, lat);
        checkOutput($sformatf("sweep_%0d_%0d", k, md), out_data, ref_state(d, m));
        finishState(ref_state(d, m));
      end
    end

    // Random states in random modes, including an inverse round-trip.
    for (int r = 0; r < 20; r++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      applyStimulus(d, m, lat);
      e = ref_state(d, m);
      checkOutput($sformatf("rand_%0d", r), out_data, e);
      finishState(e);
      applyStimulus(e, ~m, lat);
      checkOutput($sformatf("rand_round_trip_%0d", r), out_data, d);
      finishState(d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
